mac_tap_sequencer: RTL and testbench

//  Upstream feeder for the 32-bit accumulator in the approximate MAC edge-detection path.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_tap_sequencer_if.sv | 29 ++
 rtl/approx_mul.sv | 40 ++++
 rtl/mac_tap_sequencer.sv | 108 ++++++++++
 tb/tb_mac_tap_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the MAC tap sequencer path.
// Defaults describe a 3x3 window of 8-bit unsigned pixels with 4-bit signed coefficients.
// ACC_W is the width of the downstream accumulator's input_data.
package mac_pkg;

  localparam int DEF_TAPS     = 9;
  localparam int DEF_PIX_W    = 8;
  localparam int DEF_COEF_W   = 4;
  localparam int DEF_APPROX_K = 4;
  localparam int ACC_W        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mac_tap_sequencer_if.sv
// Window-in / product-out bundle between the upstream window source, the sequencer and the accumulator.
// master = window source / observer side, slave = sequencer side.
// All sequencer-driven signals are registered inside the sequencer.
interface mac_tap_sequencer_if import mac_pkg::*; #(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS
) ();

  logic                     win_valid;
  logic                     win_ready;
  logic [TAPS*PIX_W-1:0]    win_pix;
  logic [TAPS*COEF_W-1:0]   win_coef;
  logic [ACC_W-1:0]         prod_data;
  logic                     acc_clr;
  logic                     sum_valid;
  logic                     busy;

  modport master (
    output win_valid, win_pix, win_coef,
    input  win_ready, prod_data, acc_clr, sum_valid, busy
  );

  modport slave (
    input  win_valid, win_pix, win_coef,
    output win_ready, prod_data, acc_clr, sum_valid, busy
  );

endinterface

// File: rtl/approx_mul.sv
// approx_mul: combinational unsigned pixel x signed coefficient, sign-extended to ACC_W bits.
// Latency: 0 cycles (pure combinational). No handshake.
// EXACT_MUL_EN defined: exact product; otherwise the APPROX_K pixel LSBs are zeroed first.
module approx_mul import mac_pkg::*; #(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int APPROX_K = DEF_APPROX_K
) (
  input  logic        [PIX_W-1:0]  pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  prod
);

`ifdef EXACT_MUL_EN
  localparam int K_EFF = 0 * APPROX_K;
`else
  localparam int K_EFF = APPROX_K;
`endif

  // Product width: unsigned pixel plus a zero sign bit, times the signed coefficient.
  localparam int PW = PIX_W + COEF_W + 1;
  localparam logic [PIX_W-1:0] KEEP_MASK = ~PIX_W'((1 << K_EFF) - 1);

  logic        [PIX_W-1:0] pix_eff;
  logic signed [PIX_W:0]   pix_s;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    c_ext;
  logic signed [PW-1:0]    p;

  // Truncate pixel LSBs, multiply as signed, then sign-extend to accumulator width.
  always_comb begin
    pix_eff = pix & KEEP_MASK;
    pix_s   = {1'b0, pix_eff};
    a_ext   = PW'(pix_s);
    c_ext   = PW'(coef);
    p       = a_ext * c_ext;
    prod    = ACC_W'(p);
  end

endmodule

// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: latches one window+kernel, clears the accumulator, streams TAPS products, flags the sum.
// Latency: acc_clr 1 cycle after transfer, products on cycles 2..TAPS+1, sum_valid on cycle TAPS+2 (11/window).
// Backpressure: win_ready registered, high only in IDLE/DONE; win_valid elsewhere ignored. EXACT_MUL_EN: exact products.
module mac_tap_sequencer import mac_pkg::*; #(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int APPROX_K = DEF_APPROX_K
) (
  input logic              clk,
  input logic              reset,
  mac_tap_sequencer_if.slave win
);

  localparam int TAP_W = $clog2(TAPS + 1);

  state_t                      state;
  logic [TAP_W-1:0]            tap;
  logic [TAPS*PIX_W-1:0]       pix_r;
  logic [TAPS*COEF_W-1:0]      coef_r;
  logic [TAP_W-1:0]            sel;
  logic [PIX_W-1:0]            sel_pix;
  logic signed [COEF_W-1:0]    sel_coef;
  logic signed [ACC_W-1:0]     sel_prod;
  logic                        xfer;

  // win_ready is only ever high in IDLE/DONE, so this also gates out win_valid elsewhere.
  assign xfer     = win.win_valid & win.win_ready;
  assign win.busy = (state != IDLE);

  // Tap mux: tap holds the index of the next product to issue; clamp once all taps are out.
  always_comb begin
    sel      = (tap < TAP_W'(TAPS)) ? tap : '0;
    sel_pix  = pix_r[int'(sel)*PIX_W +: PIX_W];
    sel_coef = coef_r[int'(sel)*COEF_W +: COEF_W];
  end

  approx_mul #(
    .PIX_W    (PIX_W),
    .COEF_W   (COEF_W),
    .APPROX_K (APPROX_K)
  ) u_mul (
    .pix  (sel_pix),
    .coef (sel_coef),
    .prod (sel_prod)
  );

  // Sequencer FSM with registered handshake, clear, product and sum-valid outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tap           <= '0;
      pix_r         <= '0;
      coef_r        <= '0;
      win.prod_data <= '0;
      win.acc_clr   <= 1'b0;
      win.sum_valid <= 1'b0;
      win.win_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            pix_r         <= win.win_pix;
            coef_r        <= win.win_coef;
            tap           <= '0;
            win.acc_clr   <= 1'b1;
            win.win_ready <= 1'b0;
            state         <= CLR;
          end else begin
            win.win_ready <= 1'b1;
          end
        end
        CLR: begin
          win.acc_clr   <= 1'b0;
          win.prod_data <= sel_prod;
          tap           <= tap + TAP_W'(1);
          state         <= RUN;
        end
        RUN: begin
          if (tap == TAP_W'(TAPS)) begin
            win.prod_data <= '0;
            win.sum_valid <= 1'b1;
            win.win_ready <= 1'b1;
            state         <= DONE;
          end else begin
            win.prod_data <= sel_prod;
            tap           <= tap + TAP_W'(1);
          end
        end
        DONE: begin
          win.sum_valid <= 1'b0;
          tap           <= '0;
          if (xfer) begin
            pix_r         <= win.win_pix;
            coef_r        <= win.win_coef;
            win.acc_clr   <= 1'b1;
            win.win_ready <= 1'b0;
            state         <= CLR;
          end else begin
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Directed bench: sequencer driving a behavioural 32-bit accumulator, hand-computed window sums.
// Expected values follow EXACT_MUL_EN so the bench matches either build.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mac_tap_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_tap_sequencer_if bus ();

  mac_tap_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .win   (bus)
  );

  // Downstream accumulator: async active-high clear, two's-complement wrap-around add.
  logic [31:0] acc;
  always_ff @(posedge clk or posedge bus.acc_clr)
    if (bus.acc_clr) acc <= '0;
    else             acc <= acc + bus.prod_data;

  // Sobel Gx, tap 0 in the LSBs: {1,0,-1, 2,0,-2, 1,0,-1} from tap 8 down to tap 0.
  localparam logic [35:0] GX      = 36'h10F20E10F;
  // tap0 = -8, tap1 = 7, others 0: extremes of the coefficient range.
  localparam logic [35:0] K_RANGE = 36'h000000078;
  localparam logic [35:0] K_SEVEN = {9{4'h7}};

`ifdef EXACT_MUL_EN
  localparam logic [31:0] E_SUM2  = 32'd1020;
  localparam logic [31:0] E_SUM3  = 32'hFFFFFC04;
  localparam logic [31:0] E_P1    = 32'd255;
  localparam logic [31:0] E_P2    = 32'd510;
  localparam logic [31:0] E_N1    = 32'hFFFFFF01;
  localparam logic [31:0] E_N2    = 32'hFFFFFE02;
  localparam logic [31:0] E_MIN   = 32'hFFFFF808;
  localparam logic [31:0] E_MAX   = 32'd1785;
  localparam logic [31:0] E_SUMR  = 32'hFFFFFF01;
`else
  localparam logic [31:0] E_SUM2  = 32'd960;
  localparam logic [31:0] E_SUM3  = 32'hFFFFFC40;
  localparam logic [31:0] E_P1    = 32'd240;
  localparam logic [31:0] E_P2    = 32'd480;
  localparam logic [31:0] E_N1    = 32'hFFFFFF10;
  localparam logic [31:0] E_N2    = 32'hFFFFFE20;
  localparam logic [31:0] E_MIN   = 32'hFFFFF880;
  localparam logic [31:0] E_MAX   = 32'd1680;
  localparam logic [31:0] E_SUMR  = 32'hFFFFFF10;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] tp [9];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // Columns of a 3x3 window: taps 0/3/6 left, 1/4/7 middle, 2/5/8 right.
  function automatic logic [71:0] pix_vec(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
    logic [71:0] v;
    v = '0;
    for (int row = 0; row < 3; row++) begin
      v[row*24 +: 8]      = l;
      v[row*24 + 8 +: 8]  = m;
      v[row*24 + 16 +: 8] = r;
    end
    return v;
  endfunction

  // Offer a window, wait (bounded) for ready, and return on the falling edge of the CLR cycle.
  task automatic send(input logic [71:0] pix, input logic [35:0] coef);
    int n;
    @(negedge clk);
    bus.win_valid = 1'b1;
    bus.win_pix   = pix;
    bus.win_coef  = coef;
    n = 0;
    while (bus.win_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(bus.win_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.win_valid = 1'b0;
    chk("clr_pulse", 32'(bus.acc_clr), 32'd1);
    chk("clr_prod", bus.prod_data, 32'd0);
    chk("clr_ready", 32'(bus.win_ready), 32'd0);
  endtask

  // Full window: record tap products, check sum_valid timing, sum, and return to IDLE.
  task automatic run_window(input string tag, input logic [71:0] pix, input logic [35:0] coef,
                            input logic [31:0] exp_sum, input bit poke);
    int lat;
    lat = -1;
    send(pix, coef);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (poke && k == 3) begin
        chk({tag, "_ready_in_run"}, 32'(bus.win_ready), 32'd0);
        bus.win_valid = 1'b1;
        bus.win_pix   = ~pix;
        bus.win_coef  = ~coef;
      end
      if (poke && k == 4) bus.win_valid = 1'b0;
      if (k <= 9) tp[k-1] = bus.prod_data;
      if (bus.sum_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_sum_lat"}, lat, 32'd10);
    chk({tag, "_sum"}, acc, exp_sum);
    chk({tag, "_done_prod"}, bus.prod_data, 32'd0);
    chk({tag, "_done_ready"}, 32'(bus.win_ready), 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sv_pulse"}, 32'(bus.sum_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finished run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_clr, sv1, sv2;
    logic [31:0] s1, s2;

    reset         = 1'b0;
    bus.win_valid = 1'b0;
    bus.win_pix   = '0;
    bus.win_coef  = '0;
    repeat (2) @(negedge clk);
    chk("rst_prod", bus.prod_data, 32'd0);
    chk("rst_clr", 32'(bus.acc_clr), 32'd0);
    chk("rst_sv", 32'(bus.sum_valid), 32'd0);
    chk("rst_ready", 32'(bus.win_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.win_ready), 32'd1);

    // Flat window: Gx cancels to zero.
    run_window("t1_flat", pix_vec(8'd10, 8'd10, 8'd10), GX, 32'd0, 1'b0);

    // Rising edge left->right.
    run_window("t2_rise", pix_vec(8'd0, 8'd128, 8'd255), GX, E_SUM2, 1'b0);
    chk("t2_tap0", tp[0], 32'd0);
    chk("t2_tap2", tp[2], E_P1);
    chk("t2_tap4", tp[4], 32'd0);
    chk("t2_tap5", tp[5], E_P2);

    // Falling edge: negative sum wraps in the 32-bit accumulator.
    run_window("t3_fall", pix_vec(8'd255, 8'd128, 8'd0), GX, E_SUM3, 1'b0);
    chk("t3_tap0", tp[0], E_N1);
    chk("t3_tap3", tp[3], E_N2);

    // Coefficient extremes -8 and +7 against full-scale pixels.
    run_window("t_range", {9{8'hFF}}, K_RANGE, E_SUMR, 1'b0);
    chk("range_min", tp[0], E_MIN);
    chk("range_max", tp[1], E_MAX);

    // Back-to-back: win_valid held high across the DONE cycle of the first window.
    @(negedge clk);
    chk("b2b_ready", 32'(bus.win_ready), 32'd1);
    bus.win_valid = 1'b1;
    bus.win_pix   = pix_vec(8'd0, 8'd128, 8'd255);
    bus.win_coef  = GX;
    @(negedge clk);
    bus.win_pix   = pix_vec(8'd255, 8'd128, 8'd0);
    n_clr = 0;
    sv1   = -1;
    sv2   = -1;
    s1    = '0;
    s2    = '0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.acc_clr) begin
        n_clr++;
        if (k > 0) bus.win_valid = 1'b0;
      end
      if (bus.sum_valid) begin
        if (sv1 < 0) begin
          sv1 = k;
          s1  = acc;
        end else begin
          sv2 = k;
          s2  = acc;
        end
      end
    end
    chk("b2b_first_lat", sv1, 32'd10);
    chk("b2b_period", sv2 - sv1, 32'd11);
    chk("b2b_clr_pulses", n_clr, 32'd2);
    chk("b2b_sum1", s1, E_SUM2);
    chk("b2b_sum2", s2, E_SUM3);
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset asserted while tap 4 is on prod_data.
    send({9{8'hFF}}, K_SEVEN);
    repeat (5) @(negedge clk);
    chk("t5_tap4_live", bus.prod_data, E_MAX);
    reset = 1'b0;
    #1;
    chk("t5_rst_prod", bus.prod_data, 32'd0);
    chk("t5_rst_clr", 32'(bus.acc_clr), 32'd0);
    chk("t5_rst_sv", 32'(bus.sum_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.win_ready), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", 32'(bus.win_ready), 32'd1);
    run_window("t5_next", pix_vec(8'd255, 8'd128, 8'd0), GX, E_SUM3, 1'b0);

    // win_valid with different data mid-RUN must not disturb the current window.
    run_window("t6_poke", pix_vec(8'd0, 8'd128, 8'd255), GX, E_SUM2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
